// File: rtl/sa_cdma_img_fifo_arb.sv
// Packet-level round-robin arbiter feeding the CDMA image FIFO write port, with occupancy tracking.
// Optional per-requester beat/packet counters are built when SA_CDMA_IMG_ARB_PERF_EN is defined.
module sa_cdma_img_fifo_arb #(
   parameter int NREQ      = 2,
   parameter int DW        = 11,
   parameter int DEPTH     = 128,
   parameter int MAX_BURST = 64
) (
   input  logic                      clk,
   input  logic                      reset_,
   input  logic [NREQ-1:0]           req_vld,
   output logic [NREQ-1:0]           req_rdy,
   input  logic [NREQ*DW-1:0]        req_data,
   input  logic [NREQ-1:0]           req_last,
   output logic                      fifo_wr_req,
   input  logic                      fifo_wr_ready,
   output logic [DW-1:0]             fifo_wr_data,
   input  logic                      fifo_pop,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      burst_ovf
`ifdef SA_CDMA_IMG_ARB_PERF_EN
   ,
   output logic [NREQ*32-1:0]        perf_beats,
   output logic [NREQ*32-1:0]        perf_pkts
`endif
);

   localparam int GW = $clog2(NREQ);
   localparam int OW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [DW-1:0]   hold_q, hold_d;
   logic [OW-1:0]   occ_q, occ_d;

   logic            g_vld, g_last, accept, push, found;
   logic [DW-1:0]   g_data;
   logic [GW-1:0]   cand;

   assign g_vld  = req_vld[grant_q];
   assign g_last = req_last[grant_q];
   assign g_data = req_data[int'(grant_q)*DW +: DW];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_d         = rr_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      hold_d       = hold_q;
      req_rdy      = '0;
      fifo_wr_req  = 1'b0;
      fifo_wr_data = hold_q;
      accept       = 1'b0;
      found        = 1'b0;
      cand         = '0;
      case (state_q)
         IDLE: begin
            for (int k = 0; k < NREQ; k++) begin
               cand = GW'((int'(rr_q) + k) % NREQ);
               if (!found && req_vld[cand]) begin
                  found   = 1'b1;
                  grant_d = cand;
               end
            end
            if (found) state_d = BURST;
         end
         BURST: begin
            fifo_wr_req       = g_vld;
            fifo_wr_data      = g_data;
            hold_d            = g_data;
            req_rdy[grant_q]  = fifo_wr_ready;
            accept            = g_vld & fifo_wr_ready;
            if (accept) begin
               if (g_last) begin
                  cnt_d   = '0;
                  rr_d    = GW'((int'(grant_q) + 1) % NREQ);
                  state_d = IDLE;
               end else begin
                  if (cnt_q == CW'(MAX_BURST - 1)) ovf_d = 1'b1;
                  // Counter saturates; an oversized packet keeps its grant until last.
                  if (cnt_q < CW'(MAX_BURST)) cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign push = fifo_wr_req & fifo_wr_ready;

   always_comb begin
      occ_d = occ_q;
      if (push && !fifo_pop && occ_q < OW'(DEPTH)) occ_d = occ_q + 1'b1;
      else if (fifo_pop && !push && occ_q != '0) occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         hold_q  <= '0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         hold_q  <= hold_d;
         occ_q   <= occ_d;
      end
   end

   assign occupancy = occ_q;
   assign grant_id  = grant_q;
   assign burst_ovf = ovf_q;

`ifdef SA_CDMA_IMG_ARB_PERF_EN
   logic [31:0] beats_q [NREQ];
   logic [31:0] pkts_q  [NREQ];

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < NREQ; i++) begin
            beats_q[i] <= '0;
            pkts_q[i]  <= '0;
         end
      end else if (accept) begin
         beats_q[grant_q] <= beats_q[grant_q] + 32'd1;
         if (g_last) pkts_q[grant_q] <= pkts_q[grant_q] + 32'd1;
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_perf
      assign perf_beats[i*32 +: 32] = beats_q[i];
      assign perf_pkts[i*32 +: 32]  = pkts_q[i];
   end
`endif

endmodule

// File: tb/tb_sa_cdma_img_fifo_arb.sv
// Directed bench for sa_cdma_img_fifo_arb: cycle vector table plus hand sequences for overflow and occupancy.
module tb_sa_cdma_img_fifo_arb;

   logic        clk = 1'b0;
   logic        reset_;
   logic [1:0]  req_vld;
   logic [1:0]  req_rdy;
   logic [21:0] req_data;
   logic [1:0]  req_last;
   logic        fifo_wr_req;
   logic        fifo_wr_ready;
   logic [10:0] fifo_wr_data;
   logic        fifo_pop;
   logic [7:0]  occupancy;
   logic [0:0]  grant_id;
   logic        burst_ovf;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sa_cdma_img_fifo_arb dut (
      .clk(clk), .reset_(reset_),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data), .req_last(req_last),
      .fifo_wr_req(fifo_wr_req), .fifo_wr_ready(fifo_wr_ready), .fifo_wr_data(fifo_wr_data),
      .fifo_pop(fifo_pop), .occupancy(occupancy), .grant_id(grant_id), .burst_ovf(burst_ovf)
   );

   typedef struct {
      logic [1:0]  vld, last;
      logic [10:0] d0, d1;
      logic        rdy, pop;
      logic [1:0]  e_rdy;
      logic        e_wr;
      logic [10:0] e_data;
      logic        e_gid;
      logic [7:0]  e_occ;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input logic [1:0] vld, input logic [1:0] last, input logic [10:0] d0,
                       input logic [10:0] d1, input logic rdy, input logic pop,
                       input logic [1:0] e_rdy, input logic e_wr, input logic [10:0] e_data,
                       input logic e_gid, input logic [7:0] e_occ);
      vec_t v;
      v.vld = vld; v.last = last; v.d0 = d0; v.d1 = d1; v.rdy = rdy; v.pop = pop;
      v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_data = e_data; v.e_gid = e_gid; v.e_occ = e_occ;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drives one packet on requester req; pop_on asserts fifo_pop on the accepted beats only.
   task automatic drive_pkt(input int req, input int nbeats, input logic pop_on, input logic watch_ovf);
      int beats = 0;
      int cyc = 0;
      while (beats < nbeats && cyc < 400) begin
         @(negedge clk);
         if (watch_ovf && beats == 63) chk("ovf_before_beat64", 32'(burst_ovf), 32'd0);
         if (watch_ovf && beats == 64) chk("ovf_after_beat64", 32'(burst_ovf), 32'd1);
         req_vld = '0; req_last = '0; fifo_pop = 1'b0;
         req_vld[req]  = 1'b1;
         req_last[req] = (beats == nbeats - 1);
         req_data[req*11 +: 11] = 11'(beats);
         #1;
         if (req_rdy[req]) begin
            fifo_pop = pop_on;
            beats++;
         end
         cyc++;
      end
      if (beats < nbeats) chk("pkt_timeout", 32'(beats), 32'(nbeats));
      @(negedge clk);
      req_vld = '0; req_last = '0; fifo_pop = 1'b0;
   endtask

   initial begin
      reset_ = 1'b0; req_vld = '0; req_last = '0; req_data = '0;
      fifo_wr_ready = 1'b1; fifo_pop = 1'b0;

      //    vld   last  d0      d1      r  p   erdy  w  edata   g  occ
      addv(2'b01,2'b00,11'h101,11'h000,1,0, 2'b00,0,11'h000,0,8'd0);
      addv(2'b01,2'b00,11'h102,11'h000,1,0, 2'b01,1,11'h102,0,8'd0);
      addv(2'b01,2'b00,11'h103,11'h000,1,0, 2'b01,1,11'h103,0,8'd1);
      addv(2'b01,2'b01,11'h104,11'h000,1,0, 2'b01,1,11'h104,0,8'd2);
      addv(2'b00,2'b00,11'h000,11'h000,1,0, 2'b00,0,11'h104,0,8'd3);
      addv(2'b11,2'b00,11'h011,11'h021,1,0, 2'b00,0,11'h104,0,8'd3);
      addv(2'b11,2'b00,11'h012,11'h022,1,0, 2'b10,1,11'h022,1,8'd3);
      addv(2'b11,2'b10,11'h012,11'h023,1,0, 2'b10,1,11'h023,1,8'd4);
      addv(2'b11,2'b00,11'h013,11'h024,1,0, 2'b00,0,11'h023,1,8'd5);
      addv(2'b11,2'b00,11'h031,11'h024,1,0, 2'b01,1,11'h031,0,8'd5);
      addv(2'b11,2'b01,11'h032,11'h024,1,0, 2'b01,1,11'h032,0,8'd6);
      addv(2'b11,2'b00,11'h033,11'h040,1,0, 2'b00,0,11'h032,0,8'd7);
      addv(2'b11,2'b00,11'h033,11'h041,1,0, 2'b10,1,11'h041,1,8'd7);
      addv(2'b11,2'b10,11'h033,11'h042,1,0, 2'b10,1,11'h042,1,8'd8);
      addv(2'b10,2'b00,11'h000,11'h050,1,0, 2'b00,0,11'h042,1,8'd9);
      addv(2'b11,2'b00,11'h060,11'h051,1,0, 2'b10,1,11'h051,1,8'd9);
      for (int i = 0; i < 3; i++)
         addv(2'b01,2'b00,11'h060,11'h052,1,0, 2'b10,0,11'h052,1,8'd10);
      addv(2'b11,2'b10,11'h060,11'h053,1,0, 2'b10,1,11'h053,1,8'd10);
      addv(2'b01,2'b00,11'h061,11'h053,1,0, 2'b00,0,11'h053,1,8'd11);
      for (int i = 0; i < 5; i++)
         addv(2'b01,2'b00,11'h061,11'h000,0,0, 2'b00,1,11'h061,0,8'd11);
      addv(2'b01,2'b01,11'h061,11'h000,1,0, 2'b01,1,11'h061,0,8'd11);
      addv(2'b00,2'b00,11'h000,11'h000,1,1, 2'b00,0,11'h061,0,8'd12);
      addv(2'b00,2'b00,11'h000,11'h000,1,0, 2'b00,0,11'h061,0,8'd11);

      repeat (2) @(negedge clk);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_wr_req", 32'(fifo_wr_req), 32'd0);
      chk("rst_rdy", 32'(req_rdy), 32'd0);
      chk("rst_ovf", 32'(burst_ovf), 32'd0);
      reset_ = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         req_vld = tbl[i].vld; req_last = tbl[i].last;
         req_data = {tbl[i].d1, tbl[i].d0};
         fifo_wr_ready = tbl[i].rdy; fifo_pop = tbl[i].pop;
         #1;
         chk($sformatf("v%0d_rdy", i),  32'(req_rdy),      32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_wr", i),   32'(fifo_wr_req),  32'(tbl[i].e_wr));
         chk($sformatf("v%0d_data", i), 32'(fifo_wr_data), 32'(tbl[i].e_data));
         chk($sformatf("v%0d_gid", i),  32'(grant_id),     32'(tbl[i].e_gid));
         chk($sformatf("v%0d_occ", i),  32'(occupancy),    32'(tbl[i].e_occ));
         chk($sformatf("v%0d_ovf", i),  32'(burst_ovf),    32'd0);
      end

      // Asynchronous reset in the middle of a packet on requester 1.
      @(negedge clk);
      req_vld = 2'b10; req_last = 2'b00; fifo_wr_ready = 1'b1; fifo_pop = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_ = 1'b0;
      #1;
      chk("arst_wr_req", 32'(fifo_wr_req), 32'd0);
      chk("arst_occ", 32'(occupancy), 32'd0);
      chk("arst_gid", 32'(grant_id), 32'd0);
      chk("arst_data", 32'(fifo_wr_data), 32'd0);
      req_vld = '0;
      @(negedge clk);
      reset_ = 1'b1;

      // 65-beat packet trips the sticky overflow flag after beat 64.
      drive_pkt(0, 65, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      chk("ovf_sticky", 32'(burst_ovf), 32'd1);
      chk("occ_65", 32'(occupancy), 32'd65);

      // 65 more single-beat pushes: occupancy clamps at 128.
      for (int i = 0; i < 65; i++) drive_pkt(1, 1, 1'b0, 1'b0);
      #1;
      chk("occ_sat", 32'(occupancy), 32'd128);

      @(negedge clk); fifo_pop = 1'b1;
      @(negedge clk); fifo_pop = 1'b0; #1;
      chk("occ_pop1", 32'(occupancy), 32'd127);
      drive_pkt(0, 1, 1'b1, 1'b0);
      #1;
      chk("occ_push_pop", 32'(occupancy), 32'd127);
      chk("ovf_still", 32'(burst_ovf), 32'd1);

      for (int i = 0; i < 130; i++) begin
         @(negedge clk); fifo_pop = 1'b1;
      end
      @(negedge clk); fifo_pop = 1'b0; #1;
      chk("occ_drain", 32'(occupancy), 32'd0);

      @(negedge clk); reset_ = 1'b0;
      #1;
      chk("ovf_cleared", 32'(burst_ovf), 32'd0);
      @(negedge clk); reset_ = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
